// File: rtl/imem_line_responder_if.sv
// Bus between the fetch stage and the instruction-line responder.
//
// Handshake: fetch raises req with req_line and holds both until it sees a
// one-cycle resp_valid pulse. The responder takes the request at the first
// edge where it is idle. While busy is high, req and req_line are ignored.
// resp_line is valid in the resp_valid cycle and holds until the next response.
// A write port (wr_en/wr_addr/wr_data) updates one word at any edge. It has
// no handshake.
interface imem_line_responder_if #(
  parameter int XLEN           = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int LINE_ADDR_BITS = 3
);
  localparam int WORD_BITS = $clog2(WORDS_PER_LINE);

  logic                           req;
  logic [LINE_ADDR_BITS-1:0]      req_line;
  logic                           resp_valid;
  logic [XLEN*WORDS_PER_LINE-1:0] resp_line;
  logic                           busy;
  logic                           wr_en;
  logic [LINE_ADDR_BITS+WORD_BITS-1:0] wr_addr;
  logic [XLEN-1:0]                wr_data;

  // fetch / preload side
  modport master (
    output req, req_line, wr_en, wr_addr, wr_data,
    input  resp_valid, resp_line, busy
  );

  // responder side
  modport slave (
    input  req, req_line, wr_en, wr_addr, wr_data,
    output resp_valid, resp_line, busy
  );
endinterface

// File: rtl/imem_line_responder.sv
// Instruction-line responder. It takes a line request, waits LATENCY edges,
// then returns the whole line with a one-cycle valid pulse. The backing array
// holds WORDS_PER_LINE << LINE_ADDR_BITS words and is written one word at a time.
module imem_line_responder #(
  parameter int XLEN           = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int LINE_ADDR_BITS = 3,
  parameter int LATENCY        = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  imem_line_responder_if.slave  bus,
  output logic [1:0]            dbg_state
);

  localparam int WORD_BITS = $clog2(WORDS_PER_LINE);
  localparam int NUM_WORDS = WORDS_PER_LINE << LINE_ADDR_BITS;
  localparam int LINE_W    = XLEN * WORDS_PER_LINE;
  // The wait counter runs from LATENCY-1 down to 0. The edge after it reaches
  // 0 enters RESP. That puts the response LATENCY edges after acceptance.
  localparam int CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [LINE_ADDR_BITS-1:0] addr_q, addr_d;
  logic                      resp_valid_q;
  logic                      busy_q;
  logic [LINE_W-1:0]         resp_line_q;
  logic [LINE_W-1:0]         rd_line;
  logic                      load_resp;

  logic [XLEN-1:0] mem [NUM_WORDS];

  // Backing array: one word per edge, in any state, never reset
  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Gather the captured line from the array. A same-edge write is not seen.
  always_comb begin
    rd_line = '0;
    for (int w = 0; w < WORDS_PER_LINE; w++) begin
      rd_line[w*XLEN +: XLEN] = mem[{addr_q, WORD_BITS'(w)}];
    end
  end

  // Next-state logic: accept in IDLE, count in WAIT, pulse once in RESP
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          addr_d  = bus.req_line;
          cnt_d   = CNT_INIT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign load_resp = (state_q == S_WAIT) && (state_d == S_RESP);

  // State, address and counter registers, plus registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      resp_line_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      resp_valid_q <= (state_d == S_RESP);
      busy_q       <= (state_d != S_IDLE);
      if (load_resp) begin
        resp_line_q <= rd_line;
      end
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_line  = resp_line_q;
  assign bus.busy       = busy_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_imem_line_responder.sv
// Bench for imem_line_responder. It drives two instances from shared inputs,
// with LATENCY=4 and LATENCY=1. A reference array and an edge-count timing
// rule give the expected results.
module tb_imem_line_responder;

  localparam int XLEN = 32;
  localparam int WPL  = 4;
  localparam int LAB  = 3;
  localparam int LW   = XLEN * WPL;
  localparam int NW   = WPL << LAB;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_line_responder_if #(.XLEN(XLEN), .WORDS_PER_LINE(WPL), .LINE_ADDR_BITS(LAB)) bus4 ();
  imem_line_responder_if #(.XLEN(XLEN), .WORDS_PER_LINE(WPL), .LINE_ADDR_BITS(LAB)) bus1 ();
  logic [1:0] dbg4, dbg1;

  imem_line_responder #(.XLEN(XLEN), .WORDS_PER_LINE(WPL), .LINE_ADDR_BITS(LAB), .LATENCY(4)) u_dut4 (
    .clk(clk), .rst(rst), .bus(bus4.slave), .dbg_state(dbg4));
  imem_line_responder #(.XLEN(XLEN), .WORDS_PER_LINE(WPL), .LINE_ADDR_BITS(LAB), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave), .dbg_state(dbg1));

  // shared stimulus
  logic           req;
  logic [LAB-1:0] req_line;
  logic           wr_en;
  logic [4:0]     wr_addr;
  logic [31:0]    wr_data;
  assign bus4.req = req;   assign bus4.req_line = req_line;
  assign bus4.wr_en = wr_en; assign bus4.wr_addr = wr_addr; assign bus4.wr_data = wr_data;
  assign bus1.req = req;   assign bus1.req_line = req_line;
  assign bus1.wr_en = wr_en; assign bus1.wr_addr = wr_addr; assign bus1.wr_data = wr_data;

  // observed instance select
  bit          sel;
  logic        obs_valid, obs_busy;
  logic [LW-1:0] obs_line;
  assign obs_valid = sel ? bus1.resp_valid : bus4.resp_valid;
  assign obs_busy  = sel ? bus1.busy       : bus4.busy;
  assign obs_line  = sel ? bus1.resp_line  : bus4.resp_line;

  // reference model
  logic [31:0] ref_mem [NW];
  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;

  function automatic logic [LW-1:0] ref_line(input int line);
    logic [LW-1:0] r;
    for (int w = 0; w < WPL; w++) r[w*XLEN +: XLEN] = ref_mem[line*WPL + w];
    return r;
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    edge_cnt++;
    #1;
  endtask

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mem_write(input int addr, input logic [31:0] data);
    wr_en = 1'b1; wr_addr = addr[4:0]; wr_data = data;
    step();
    ref_mem[addr] = data;
    wr_en = 1'b0;
  endtask

  // One complete fetch, starting from idle. req_line moves to alt_line during
  // the wait. An optional collision write lands at the edge that enters RESP.
  task automatic fetch(input int lat, input int line, input int alt_line,
                       input bit collide, input int cw_word, input logic [31:0] cw_data,
                       input bit next_req, input int next_line, output int acc_edge);
    logic [LW-1:0] exp;
    exp = '0;
    req = 1'b1; req_line = line[LAB-1:0];
    step();
    acc_edge = edge_cnt;
    check("accept_busy", obs_busy, 1);
    check("accept_valid", obs_valid, 0);
    req_line = alt_line[LAB-1:0];
    for (int n = 1; n <= lat; n++) begin
      if (n == lat) begin
        exp = ref_line(line);
        if (collide) begin
          wr_en = 1'b1; wr_addr = 5'(line*WPL + cw_word); wr_data = cw_data;
        end
      end
      step();
      if (n == lat && collide) begin
        ref_mem[line*WPL + cw_word] = cw_data;
        wr_en = 1'b0;
      end
      check("wait_busy", obs_busy, 1);
      check("valid_timing", obs_valid, (n == lat));
      if (n == lat) check("resp_line", obs_line, exp);
    end
    req = next_req; req_line = next_line[LAB-1:0];
    step();
    check("leave_valid", obs_valid, 0);
    check("leave_busy", obs_busy, 0);
    check("hold_line", obs_line, exp);
  endtask

  initial begin
    int a1, a2, rel;
    logic [31:0] old_w, rd;
    logic [LW-1:0] cur;

    rst = 1'b1; req = 1'b1; req_line = 3'd2; wr_en = 1'b0; wr_addr = '0; wr_data = '0; sel = 1'b0;
    #1;
    check("rst0_valid", bus4.resp_valid, 0);
    check("rst0_busy", bus4.busy, 0);
    // reset held for 3 edges with req high
    for (int c = 0; c < 3; c++) begin
      step();
      check("rst_valid4", bus4.resp_valid, 0);
      check("rst_busy4", bus4.busy, 0);
      check("rst_line4", bus4.resp_line, 0);
      check("rst_valid1", bus1.resp_valid, 0);
      check("rst_busy1", bus1.busy, 0);
      check("rst_line1", bus1.resp_line, 0);
    end

    // preload the array while still in reset
    for (int a = 0; a < NW; a++) mem_write(a, $urandom);
    mem_write(8,  32'h00500113);
    mem_write(9,  32'h00100093);
    mem_write(10, 32'h00000013);
    mem_write(11, 32'h200000ee);

    // single fetch of line 2, accepted at the first edge after release
    rst = 1'b0;
    rel = edge_cnt;
    fetch(4, 2, 2, 1'b0, 0, 32'h0, 1'b0, 0, a1);
    check("first_accept_edge", a1 - rel, 1);
    cur = obs_line;
    check("line2_word0", cur[31:0], 32'h00500113);
    check("line2_word3", cur[127:96], 32'h200000ee);

    // address change during the wait is ignored
    fetch(4, 1, 5, 1'b0, 0, 32'h0, 1'b0, 0, a1);

    // back-to-back with req held high
    fetch(4, 0, 6, 1'b0, 0, 32'h0, 1'b1, 3, a1);
    fetch(4, 3, 1, 1'b0, 0, 32'h0, 1'b0, 0, a2);
    check("b2b_spacing4", a2 - a1, 6);

    // write collision on the edge entering RESP
    old_w = ref_mem[4*WPL + 1];
    fetch(4, 4, 0, 1'b1, 1, 32'hDEADBEEF, 1'b0, 0, a1);
    cur = obs_line;
    check("collide_old", cur[63:32], old_w);
    fetch(4, 4, 7, 1'b0, 0, 32'h0, 1'b0, 0, a1);
    cur = obs_line;
    check("collide_new", cur[63:32], 32'hDEADBEEF);

    // randomized fetches with interleaved writes
    for (int i = 0; i < 8; i++) begin
      rd = $urandom;
      mem_write($urandom_range(0, NW-1), rd);
      fetch(4, $urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
            $urandom_range(0, WPL-1), $urandom, 1'b0, 0, a1);
    end

    // reset two edges after acceptance
    req = 1'b1; req_line = 3'd6;
    step();
    check("midrst_accept_busy", bus4.busy, 1);
    step();
    step();
    rst = 1'b1;
    #1;
    check("midrst_busy", bus4.busy, 0);
    check("midrst_valid", bus4.resp_valid, 0);
    check("midrst_line", bus4.resp_line, 0);
    for (int c = 0; c < 3; c++) begin
      step();
      check("midrst_no_pulse", bus4.resp_valid, 0);
    end
    req = 1'b0;
    rst = 1'b0;
    step();
    check("postrst_idle", bus4.busy, 0);

    // LATENCY=1 instance
    sel = 1'b1;
    fetch(1, 5, 2, 1'b0, 0, 32'h0, 1'b1, 7, a1);
    fetch(1, 7, 3, 1'b1, 3, $urandom, 1'b0, 0, a2);
    check("b2b_spacing1", a2 - a1, 3);
    for (int i = 0; i < 4; i++) begin
      fetch(1, $urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
            $urandom_range(0, WPL-1), $urandom, 1'b0, 0, a1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
